pci_cfg_msi_bank: RTL and testbench

PCI_CFG_MSI_BANK -- requirements
Module: pci_cfg_msi_bank

---
 rtl/pci_cfg_msi_bank.sv | 222 ++++++++++++++++++++++
 tb/tb_pci_cfg_msi_bank.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pci_cfg_msi_bank.sv
// PCI type-0 configuration space bank with memory BARs, an MSI capability
// and a small interrupt FSM that delivers MSI or falls back to INTx.
`timescale 1ns/1ps
module pci_cfg_msi_bank #(
  parameter int NUM_BARS      = 1,
  parameter int BAR_SIZE_LOG2 = 12,
  parameter int MSI_VEC_LOG2  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_enable,
  input  logic        cfg_iswrite,
  input  logic [5:0]  cfg_offset,
  input  logic [3:0]  cfg_byte_en,
  input  logic [31:0] cfg_write_val,
  output logic [31:0] cfg_read_val,
  output logic        cfg_ack,
  input  logic [5:0]  err_events,
  input  logic        intr_valid,
  input  logic [4:0]  intr_vector,
  output logic        intr_ready,
  input  logic        intr_clear,
  output logic        msi_req,
  output logic [63:0] msi_addr,
  output logic [31:0] msi_data,
  input  logic        msi_ack,
  output logic        intx_assert,
  output logic        mem_space_en,
  output logic        bus_master_en
);

  // Handshake: a request is any cycle with cfg_enable=1; it is acknowledged by
  // cfg_ack=1 exactly one cycle later. An interrupt request is taken only when
  // intr_valid=1 and intr_ready=1; an MSI is outstanding while msi_req=1 and
  // completes on the cycle msi_ack=1 is seen.

  localparam logic [31:0] DEV_ID     = 32'h11e8_1234;
  localparam logic [31:0] CLASS_REV  = 32'hff00_0010;
  localparam logic [31:0] CAP_PTR    = 32'h0000_0040;
  localparam logic [15:0] CMD_RW     = 16'h0757;
  localparam logic [31:0] BAR_MASK   = 32'hffff_ffff << BAR_SIZE_LOG2;
  localparam logic [2:0]  MME_MAX    = 3'(MSI_VEC_LOG2);

  typedef enum logic {S_IDLE, S_MSI} state_t;

  state_t      state;
  logic [15:0] cmd_q;
  logic [5:0]  sticky_q;
  logic        intx_pending_q;
  logic [7:0]  cacheline_q;
  logic [4:0]  lat_q;
  logic [31:0] bar_q [NUM_BARS];
  logic [7:0]  int_line_q;
  logic        msi_en_q;
  logic [2:0]  mme_q;
  logic [31:0] addr_lo_q;
  logic [31:0] addr_hi_q;
  logic [15:0] data_q;

  logic        wr;
  logic [31:0] rd_data;
  logic [15:0] status;
  logic [5:0]  sticky_clr;
  logic        msi_go;
  logic        intx_set;
  logic [15:0] vec_mask;
  logic [2:0]  mme_wr;

  assign wr            = cfg_enable & cfg_iswrite;
  assign mem_space_en  = cmd_q[1];
  assign bus_master_en = cmd_q[2];
  assign intr_ready    = (state == S_IDLE);
  assign intx_assert   = intx_pending_q & ~cmd_q[10];
  assign msi_go        = msi_en_q & cmd_q[2];
  assign intx_set      = (state == S_IDLE) & intr_valid & ~msi_go;
  assign vec_mask      = (16'd1 << mme_q) - 16'd1;
  assign mme_wr        = (cfg_write_val[22:20] > MME_MAX) ? MME_MAX : cfg_write_val[22:20];

  // Status upper half: sticky error bits, capability-list bit, INTx pending.
  assign status = {sticky_q[5:1], 2'b00, sticky_q[0], 3'b000, 1'b1, intx_pending_q, 3'b000};

  // Write-1-to-clear mask for the sticky bits, only when the top byte is enabled.
  assign sticky_clr = (wr && cfg_offset == 6'h01 && cfg_byte_en[3]) ?
                      {cfg_write_val[31:27], cfg_write_val[24]} : 6'b0;

  // Read mux: assemble the addressed dword from the field registers.
  always_comb begin
    rd_data = 32'h0;
    case (cfg_offset)
      6'h00:   rd_data = DEV_ID;
      6'h01:   rd_data = {status, cmd_q};
      6'h02:   rd_data = CLASS_REV;
      6'h03:   rd_data = {16'h0, lat_q, 3'b000, cacheline_q};
      6'h0b:   rd_data = DEV_ID;
      6'h0d:   rd_data = CAP_PTR;
      6'h0f:   rd_data = {16'h0, 8'h01, int_line_q};
      6'h10:   rd_data = {8'h00, 1'b1, mme_q, MME_MAX, msi_en_q, 8'h00, 8'h05};
      6'h11:   rd_data = addr_lo_q;
      6'h12:   rd_data = addr_hi_q;
      6'h13:   rd_data = {16'h0, data_q};
      default: begin
        for (int n = 0; n < NUM_BARS; n++) begin
          if (cfg_offset == 6'(4 + n)) rd_data = bar_q[n];
        end
      end
    endcase
  end

  // Completion path: ack every request one cycle later, latch read data only on reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ack      <= 1'b0;
      cfg_read_val <= 32'h0;
    end else begin
      cfg_ack <= cfg_enable;
      if (cfg_enable && !cfg_iswrite) cfg_read_val <= rd_data;
    end
  end

  // Configuration field registers with per-byte write enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q       <= 16'h0;
      sticky_q    <= 6'h0;
      cacheline_q <= 8'h0;
      lat_q       <= 5'h0;
      int_line_q  <= 8'h0;
      msi_en_q    <= 1'b0;
      mme_q       <= 3'h0;
      addr_lo_q   <= 32'h0;
      addr_hi_q   <= 32'h0;
      data_q      <= 16'h0;
      for (int n = 0; n < NUM_BARS; n++) bar_q[n] <= 32'h0;
    end else begin
      // A new error pulse wins over a same-cycle clear.
      sticky_q <= (sticky_q & ~sticky_clr) | err_events;
      if (wr) begin
        case (cfg_offset)
          6'h01: begin
            if (cfg_byte_en[0]) cmd_q[7:0]  <= cfg_write_val[7:0]  & CMD_RW[7:0];
            if (cfg_byte_en[1]) cmd_q[15:8] <= cfg_write_val[15:8] & CMD_RW[15:8];
          end
          6'h03: begin
            if (cfg_byte_en[0]) cacheline_q <= cfg_write_val[7:0];
            if (cfg_byte_en[1]) lat_q       <= cfg_write_val[15:11];
          end
          6'h0f: if (cfg_byte_en[0]) int_line_q <= cfg_write_val[7:0];
          6'h10: begin
            if (cfg_byte_en[2]) begin
              msi_en_q <= cfg_write_val[16];
              mme_q    <= mme_wr;
            end
          end
          6'h11: begin
            for (int b = 0; b < 4; b++)
              if (cfg_byte_en[b]) addr_lo_q[8*b +: 8] <= cfg_write_val[8*b +: 8] & {6'h3f, b == 0 ? 2'b00 : 2'b11};
          end
          6'h12: begin
            for (int b = 0; b < 4; b++)
              if (cfg_byte_en[b]) addr_hi_q[8*b +: 8] <= cfg_write_val[8*b +: 8];
          end
          6'h13: begin
            if (cfg_byte_en[0]) data_q[7:0]  <= cfg_write_val[7:0];
            if (cfg_byte_en[1]) data_q[15:8] <= cfg_write_val[15:8];
          end
          default: begin
            for (int n = 0; n < NUM_BARS; n++) begin
              if (cfg_offset == 6'(4 + n)) begin
                for (int b = 0; b < 4; b++)
                  if (cfg_byte_en[b]) bar_q[n][8*b +: 8] <= cfg_write_val[8*b +: 8] & BAR_MASK[8*b +: 8];
              end
            end
          end
        endcase
      end
    end
  end

  // Legacy INTx pending flag: set by an interrupt that cannot go out as MSI; clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      intx_pending_q <= 1'b0;
    end else if (intr_clear) begin
      intx_pending_q <= 1'b0;
    end else if (intx_set) begin
      intx_pending_q <= 1'b1;
    end
  end

  // Interrupt FSM: capture the MSI message on entry and hold it until acknowledged.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      msi_req  <= 1'b0;
      msi_addr <= 64'h0;
      msi_data <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (intr_valid && msi_go) begin
            state    <= S_MSI;
            msi_req  <= 1'b1;
            msi_addr <= {addr_hi_q, addr_lo_q};
            msi_data <= {16'h0, (data_q & ~vec_mask) | (16'(intr_vector) & vec_mask)};
          end
        end
        S_MSI: begin
          // MSI enable being cleared here does not abort the outstanding message.
          if (msi_ack) begin
            state   <= S_IDLE;
            msi_req <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          msi_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_cfg_msi_bank.sv
// Self-checking bench for pci_cfg_msi_bank: config reads/writes against
// constant expectations, sticky status, BARs, MSI delivery and INTx fallback.
`timescale 1ns/1ps
module tb_pci_cfg_msi_bank;

  localparam int NUM_BARS      = 2;
  localparam int BAR_SIZE_LOG2 = 12;
  localparam int MSI_VEC_LOG2  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_enable = 1'b0;
  logic        cfg_iswrite = 1'b0;
  logic [5:0]  cfg_offset = 6'h0;
  logic [3:0]  cfg_byte_en = 4'h0;
  logic [31:0] cfg_write_val = 32'h0;
  logic [31:0] cfg_read_val;
  logic        cfg_ack;
  logic [5:0]  err_events = 6'h0;
  logic        intr_valid = 1'b0;
  logic [4:0]  intr_vector = 5'h0;
  logic        intr_ready;
  logic        intr_clear = 1'b0;
  logic        msi_req;
  logic [63:0] msi_addr;
  logic [31:0] msi_data;
  logic        msi_ack = 1'b0;
  logic        intx_assert;
  logic        mem_space_en;
  logic        bus_master_en;

  pci_cfg_msi_bank #(
    .NUM_BARS(NUM_BARS), .BAR_SIZE_LOG2(BAR_SIZE_LOG2), .MSI_VEC_LOG2(MSI_VEC_LOG2)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_enable(cfg_enable), .cfg_iswrite(cfg_iswrite), .cfg_offset(cfg_offset),
    .cfg_byte_en(cfg_byte_en), .cfg_write_val(cfg_write_val),
    .cfg_read_val(cfg_read_val), .cfg_ack(cfg_ack),
    .err_events(err_events), .intr_valid(intr_valid), .intr_vector(intr_vector),
    .intr_ready(intr_ready), .intr_clear(intr_clear),
    .msi_req(msi_req), .msi_addr(msi_addr), .msi_data(msi_data), .msi_ack(msi_ack),
    .intx_assert(intx_assert), .mem_space_en(mem_space_en), .bus_master_en(bus_master_en)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [63:0] msi_addr_q[$];
  logic [31:0] msi_data_q[$];
  logic [31:0] last_rd = 32'h0;
  logic        ack_due = 1'b0;
  logic        msi_req_seen = 1'b0;
  logic        mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Driver tasks: each drives one cycle starting just after a rising edge.
  task automatic cfg_wr(input logic [5:0] off, input logic [3:0] be, input logic [31:0] val);
    @(posedge clk); #1;
    cfg_enable = 1'b1; cfg_iswrite = 1'b1; cfg_offset = off;
    cfg_byte_en = be; cfg_write_val = val;
    exp_q.push_back(last_rd);
  endtask

  task automatic cfg_rd(input logic [5:0] off, input logic [31:0] exp);
    @(posedge clk); #1;
    cfg_enable = 1'b1; cfg_iswrite = 1'b0; cfg_offset = off;
    cfg_byte_en = 4'h0; cfg_write_val = 32'h0;
    exp_q.push_back(exp);
    last_rd = exp;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cfg_enable = 1'b0; cfg_iswrite = 1'b0;
    end
  endtask

  task automatic send_intr(input logic [4:0] vec);
    @(posedge clk); #1;
    intr_valid = 1'b1; intr_vector = vec;
    @(posedge clk); #1;
    intr_valid = 1'b0;
  endtask

  task automatic wait_msi_req();
    int k;
    k = 0;
    while (!msi_req && k < 8) begin
      @(posedge clk); #1;
      k++;
    end
    check("msi_req_rise", 64'(msi_req), 64'd1);
  endtask

  // Scoreboard monitor: every request must be acked next cycle with the queued value.
  always @(posedge clk) ack_due <= cfg_enable;

  always @(negedge clk) begin
    if (mon_en) begin
      check("cfg_ack", 64'(cfg_ack), 64'(ack_due));
      if (ack_due) begin
        if (exp_q.size() > 0) check("cfg_read_val", 64'(cfg_read_val), 64'(exp_q.pop_front()));
        else check("rd_q_size", 64'(exp_q.size()), 64'd1);
      end
      if (msi_req && !msi_req_seen) begin
        if (msi_data_q.size() > 0) begin
          check("msi_data", 64'(msi_data), 64'(msi_data_q.pop_front()));
          check("msi_addr", msi_addr, msi_addr_q.pop_front());
        end else begin
          check("msi_q_size", 64'(msi_data_q.size()), 64'd1);
        end
      end
      msi_req_seen = msi_req;
    end
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cfg_ack", 64'(cfg_ack), 64'd0);
    check("rst_read_val", 64'(cfg_read_val), 64'd0);
    check("rst_msi_req", 64'(msi_req), 64'd0);
    check("rst_msi_addr", msi_addr, 64'd0);
    check("rst_msi_data", 64'(msi_data), 64'd0);
    check("rst_intx", 64'(intx_assert), 64'd0);
    check("rst_intr_ready", 64'(intr_ready), 64'd1);
    check("rst_mem_en", 64'(mem_space_en), 64'd0);
    check("rst_bm_en", 64'(bus_master_en), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Fixed identification registers and reset field values
    cfg_rd(6'h00, 32'h11e8_1234);
    cfg_rd(6'h01, 32'h0010_0000);
    cfg_rd(6'h02, 32'hff00_0010);
    cfg_rd(6'h0b, 32'h11e8_1234);
    cfg_rd(6'h0d, 32'h0000_0040);
    cfg_rd(6'h0f, 32'h0000_0100);
    cfg_rd(6'h10, 32'h0084_0005);
    cfg_rd(6'h20, 32'h0000_0000);
    idle(1);

    // BARs: implemented ones keep address bits, unimplemented read zero
    cfg_wr(6'h04, 4'hf, 32'hffff_ffff);
    cfg_rd(6'h04, 32'hffff_f000);
    cfg_wr(6'h05, 4'hf, 32'h1234_5678);
    cfg_rd(6'h05, 32'h1234_5000);
    cfg_wr(6'h06, 4'hf, 32'hffff_ffff);
    cfg_rd(6'h06, 32'h0000_0000);
    idle(1);

    // Command register byte enables and RW mask
    cfg_wr(6'h01, 4'b0001, 32'h1234_5678);
    cfg_rd(6'h01, 32'h0010_0050);
    cfg_wr(6'h01, 4'b0000, 32'hffff_ffff);
    cfg_rd(6'h01, 32'h0010_0050);
    idle(1);
    @(negedge clk);
    check("mem_en_off", 64'(mem_space_en), 64'd0);
    check("bm_en_off", 64'(bus_master_en), 64'd0);
    cfg_wr(6'h01, 4'b0011, 32'h0000_0006);
    cfg_rd(6'h01, 32'h0010_0006);
    idle(1);
    @(negedge clk);
    check("mem_en_on", 64'(mem_space_en), 64'd1);
    check("bm_en_on", 64'(bus_master_en), 64'd1);

    // Sticky status: set by pulse, set wins over same-cycle clear, then clears
    idle(1);
    err_events = 6'b000010;
    idle(1);
    err_events = 6'b000000;
    cfg_rd(6'h01, 32'h0810_0006);
    cfg_wr(6'h01, 4'b1000, 32'h0800_0000);
    err_events = 6'b000010;
    cfg_rd(6'h01, 32'h0810_0006);
    err_events = 6'b000000;
    cfg_wr(6'h01, 4'b1000, 32'h0800_0000);
    cfg_rd(6'h01, 32'h0010_0006);
    idle(1);
    err_events = 6'h3f;
    idle(1);
    err_events = 6'h00;
    cfg_rd(6'h01, 32'hf910_0006);
    cfg_wr(6'h01, 4'b1000, 32'hff00_0000);
    cfg_rd(6'h01, 32'h0010_0006);

    // Misc RW fields
    cfg_wr(6'h03, 4'hf, 32'hffff_ffff);
    cfg_rd(6'h03, 32'h0000_f8ff);
    cfg_wr(6'h0f, 4'hf, 32'hffff_ffff);
    cfg_rd(6'h0f, 32'h0000_01ff);

    // MSI capability: MME clamps, message built from vector
    cfg_wr(6'h10, 4'b0100, 32'h0071_0000);
    cfg_rd(6'h10, 32'h00a5_0005);
    cfg_wr(6'h11, 4'hf, 32'hdead_beef);
    cfg_rd(6'h11, 32'hdead_beec);
    cfg_wr(6'h12, 4'hf, 32'h0123_4567);
    cfg_rd(6'h12, 32'h0123_4567);
    cfg_wr(6'h13, 4'hf, 32'hffff_4100);
    cfg_rd(6'h13, 32'h0000_4100);
    idle(1);
    msi_addr_q.push_back(64'h0123_4567_dead_beec);
    msi_data_q.push_back(32'h0000_4101);
    send_intr(5'd5);
    wait_msi_req();
    check("msi_busy", 64'(intr_ready), 64'd0);
    cfg_wr(6'h10, 4'b0100, 32'h0000_0000);
    idle(4);
    @(negedge clk);
    check("msi_hold_req", 64'(msi_req), 64'd1);
    check("msi_hold_data", 64'(msi_data), 64'h0000_4101);
    check("msi_hold_addr", msi_addr, 64'h0123_4567_dead_beec);
    @(posedge clk); #1;
    msi_ack = 1'b1;
    @(posedge clk); #1;
    msi_ack = 1'b0;
    @(negedge clk);
    check("msi_done_req", 64'(msi_req), 64'd0);
    check("msi_done_ready", 64'(intr_ready), 64'd1);

    // INTx fallback with MSI disabled
    send_intr(5'd3);
    @(negedge clk);
    check("intx_on", 64'(intx_assert), 64'd1);
    check("intx_no_msi", 64'(msi_req), 64'd0);
    cfg_rd(6'h01, 32'h0018_0006);
    cfg_wr(6'h01, 4'b0010, 32'h0000_0400);
    cfg_rd(6'h01, 32'h0018_0406);
    idle(1);
    @(negedge clk);
    check("intx_disabled", 64'(intx_assert), 64'd0);
    @(posedge clk); #1;
    intr_clear = 1'b1;
    @(posedge clk); #1;
    intr_clear = 1'b0;
    cfg_rd(6'h01, 32'h0010_0406);
    idle(1);

    // Reset while an MSI is outstanding
    cfg_wr(6'h10, 4'b0100, 32'h0001_0000);
    idle(1);
    msi_addr_q.push_back(64'h0123_4567_dead_beec);
    msi_data_q.push_back(32'h0000_4100);
    send_intr(5'd7);
    wait_msi_req();
    @(posedge clk); #1;
    rst = 1'b1;
    last_rd = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_msi_drop", 64'(msi_req), 64'd0);
    check("rst_msi_ready", 64'(intr_ready), 64'd1);
    check("rst_msi_data2", 64'(msi_data), 64'd0);
    check("rst_read_val2", 64'(cfg_read_val), 64'd0);
    cfg_rd(6'h01, 32'h0010_0000);
    cfg_rd(6'h04, 32'h0000_0000);
    cfg_rd(6'h10, 32'h0084_0005);
    idle(3);

    check("rd_q_left", 64'(exp_q.size()), 64'd0);
    check("msi_q_left", 64'(msi_data_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
